// File: rtl/order_dispatcher.sv
// order_dispatcher
//   Queues confirmed orders in a small FIFO and walks each one through a
//   shared preparation station: main dish (size-scaled), optional side,
//   optional drink. The finished order is then held until the customer
//   picks it up.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   ord_valid    one-cycle confirm pulse from the ordering FSM
//   ord_data     order word {tipo, tamano[1:0], principal[1:0], acomp, bebida}
//   pickup       single-cycle pickup pulse (ignored outside READY)
//   ord_ready    FIFO not full
//   ord_drop     one-cycle pulse, the cycle after an order hit a full FIFO
//   busy         station not IDLE
//   stage        0 IDLE, 1 MAIN, 2 SIDE, 3 DRINK, 4 READY
//   serve_valid  order finished, awaiting pickup
//   serving      order word held in the station, 0 when IDLE
//   queue_count  orders waiting in the FIFO
//   timeout_cnt  saturating count of orders abandoned at pickup
//                (only when PICKUP_TIMEOUT_EN is defined)
//
// Build option
//   PICKUP_TIMEOUT_EN  READY gives up after PICKUP_TO cycles without pickup.

module order_dispatcher #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAIN_CYC  = 16,
  parameter int unsigned SIDE_CYC  = 8,
  parameter int unsigned DRINK_CYC = 4,
  parameter int unsigned PICKUP_TO = 64,
  parameter int unsigned TW        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ord_valid,
  input  logic [6:0]               ord_data,
  input  logic                     pickup,
  output logic                     ord_ready,
  output logic                     ord_drop,
  output logic                     busy,
  output logic [2:0]               stage,
  output logic                     serve_valid,
  output logic [6:0]               serving,
  output logic [$clog2(DEPTH):0]   queue_count
`ifdef PICKUP_TIMEOUT_EN
  ,
  output logic [7:0]               timeout_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAIN  = 3'd1,
    SIDE  = 3'd2,
    DRINK = 3'd3,
    READY = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [6:0]      cur_order;

  logic [6:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            push;
  logic            pop;

  // Full is judged on the registered count, so a pop in the same cycle
  // never makes room for a push that arrives with the FIFO full.
  assign full = (count == FULL_CNT);
  assign push = ord_valid && !full;
  assign pop  = (state == IDLE) && (count != '0);

  assign ord_ready   = !full;
  assign queue_count = count;
  assign stage       = state;
  assign busy        = (state != IDLE);
  assign serve_valid = (state == READY);
  assign serving     = cur_order;

  // Timer load values are duration-1: the stage ends on the edge where the
  // timer already reads zero.
  function automatic logic [TW-1:0] main_load(input logic [1:0] tamano);
    logic [TW-1:0] v;
    unique case (tamano)
      2'b00:   v = TW'(MAIN_CYC - 1);
      2'b01:   v = TW'(2 * MAIN_CYC - 1);
      default: v = TW'(3 * MAIN_CYC - 1);
    endcase
    return v;
  endfunction

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ord_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      cur_order <= '0;
      ord_drop  <= 1'b0;
`ifdef PICKUP_TIMEOUT_EN
      timeout_cnt <= '0;
`endif
    end else begin
      ord_drop <= ord_valid && full;

      unique case (state)
        IDLE: begin
          if (pop) begin
            cur_order <= mem[rd_ptr];
            timer     <= main_load(mem[rd_ptr][5:4]);
            state     <= MAIN;
          end
        end

        MAIN: begin
          if (timer == '0) begin
            if (cur_order[1]) begin
              state <= SIDE;
              timer <= TW'(SIDE_CYC - 1);
            end else if (cur_order[0]) begin
              state <= DRINK;
              timer <= TW'(DRINK_CYC - 1);
            end else begin
              state <= READY;
              timer <= TW'(PICKUP_TO - 1);
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        SIDE: begin
          if (timer == '0) begin
            if (cur_order[0]) begin
              state <= DRINK;
              timer <= TW'(DRINK_CYC - 1);
            end else begin
              state <= READY;
              timer <= TW'(PICKUP_TO - 1);
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        DRINK: begin
          if (timer == '0) begin
            state <= READY;
            timer <= TW'(PICKUP_TO - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end

        READY: begin
          // A pickup on the expiry cycle takes priority over the timeout.
          if (pickup) begin
            state     <= IDLE;
            cur_order <= '0;
            timer     <= '0;
          end
`ifdef PICKUP_TIMEOUT_EN
          else if (timer == '0) begin
            state     <= IDLE;
            cur_order <= '0;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
`endif
        end

        default: begin
          state     <= IDLE;
          cur_order <= '0;
          timer     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_dispatcher.sv
// tb_order_dispatcher
//   Self-checking bench for order_dispatcher: a table of directed vectors,
//   hand-written multi-cycle sequences and a randomized run, all compared
//   against a queue-based reference model of the station.

module tb_order_dispatcher;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAIN_CYC  = 16;
  localparam int unsigned SIDE_CYC  = 8;
  localparam int unsigned DRINK_CYC = 4;
  localparam int unsigned PICKUP_TO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       ord_valid;
  logic [6:0] ord_data;
  logic       pickup;
  logic       ord_ready;
  logic       ord_drop;
  logic       busy;
  logic [2:0] stage;
  logic       serve_valid;
  logic [6:0] serving;
  logic [2:0] queue_count;
`ifdef PICKUP_TIMEOUT_EN
  logic [7:0] timeout_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  order_dispatcher #(
    .DEPTH    (DEPTH),
    .MAIN_CYC (MAIN_CYC),
    .SIDE_CYC (SIDE_CYC),
    .DRINK_CYC(DRINK_CYC),
    .PICKUP_TO(PICKUP_TO),
    .TW       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ord_valid  (ord_valid),
    .ord_data   (ord_data),
    .pickup     (pickup),
    .ord_ready  (ord_ready),
    .ord_drop   (ord_drop),
    .busy       (busy),
    .stage      (stage),
    .serve_valid(serve_valid),
    .serving    (serving),
    .queue_count(queue_count)
`ifdef PICKUP_TIMEOUT_EN
    ,
    .timeout_cnt(timeout_cnt)
`endif
  );

  // ---------------- reference model ----------------
  logic [6:0] mq[$];
  logic [6:0] m_cur;
  int         m_plan[$];
  int         m_idx;
  int         m_st;
  int         m_rem;
  bit         m_drop;
  int         m_tcnt;

  function automatic int dur(input int st, input logic [6:0] o);
    case (st)
      1: return (o[5:4] == 2'b00) ? MAIN_CYC : (o[5:4] == 2'b01) ? 2 * MAIN_CYC : 3 * MAIN_CYC;
      2: return SIDE_CYC;
      3: return DRINK_CYC;
      default: return PICKUP_TO;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_plan.delete();
    m_cur  = '0;
    m_idx  = 0;
    m_st   = 0;
    m_rem  = 0;
    m_drop = 0;
    m_tcnt = 0;
  endtask

  task automatic model_idle();
    m_st  = 0;
    m_cur = '0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input bit v, input logic [6:0] d, input bit p);
    int cb;
    cb = mq.size();
    m_drop = v && (cb == DEPTH);
    if (m_st == 0) begin
      if (cb > 0) begin
        m_cur = mq.pop_front();
        m_plan.delete();
        m_plan.push_back(1);
        if (m_cur[1]) m_plan.push_back(2);
        if (m_cur[0]) m_plan.push_back(3);
        m_plan.push_back(4);
        m_idx = 0;
        m_st  = 1;
        m_rem = dur(1, m_cur);
      end
    end else if (m_st == 4) begin
      if (p) begin
        model_idle();
      end
`ifdef PICKUP_TIMEOUT_EN
      else begin
        m_rem--;
        if (m_rem == 0) begin
          model_idle();
          if (m_tcnt < 255) m_tcnt++;
        end
      end
`endif
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_idx++;
        m_st  = m_plan[m_idx];
        m_rem = dur(m_st, m_cur);
      end
    end
    if (v && cb < DEPTH) mq.push_back(d);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("stage",       stage,       m_st);
    check("busy",        busy,        (m_st != 0));
    check("serve_valid", serve_valid, (m_st == 4));
    check("serving",     serving,     m_cur);
    check("queue_count", queue_count, mq.size());
    check("ord_ready",   ord_ready,   (mq.size() < DEPTH));
    check("ord_drop",    ord_drop,    m_drop);
`ifdef PICKUP_TIMEOUT_EN
    check("timeout_cnt", timeout_cnt, m_tcnt);
`endif
  endtask

  // One clock: inputs applied from a negedge, outputs sampled at the next negedge.
  task automatic tick(input bit v, input logic [6:0] d, input bit p);
    ord_valid = v;
    ord_data  = d;
    pickup    = p;
    model_step(v, d, p);
    @(posedge clk);
    @(negedge clk);
    ord_valid = 1'b0;
    ord_data  = '0;
    pickup    = 1'b0;
    compare_model();
  endtask

  task automatic wait_ready(input string name);
    for (int n = 0; n < 300 && stage != 3'd4; n++) tick(0, '0, 0);
    check(name, stage, 4);
  endtask

  // Reset asserted between edges; the outputs must clear without a clock.
  task automatic reset_mid();
    #2 reset = 1'b1;
    #1;
    check("rst_async_stage", stage,       0);
    check("rst_async_qc",    queue_count, 0);
    check("rst_async_sv",    serve_valid, 0);
    check("rst_async_serv",  serving,     0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         v;
    logic [6:0] d;
    bit         p;
    int         hold;      // extra idle clocks after the applied one
    int         e_stage;
    int         e_sv;
    int         e_serving;
    int         e_qc;
    int         e_busy;
  } vec_t;

  vec_t tbl[15];

  logic [6:0] w[5];
  logic [6:0] got[$];

  initial begin
    // v d p hold | stage sv serving qc busy
    tbl[0]  = '{1, 7'h1B, 0, 0,  0, 0, 7'h00, 1, 0};  // accepted, not yet popped
    tbl[1]  = '{0, 7'h00, 0, 0,  1, 0, 7'h1B, 0, 1};  // k+1: MAIN
    tbl[2]  = '{0, 7'h00, 0, 30, 1, 0, 7'h1B, 0, 1};  // k+32: still MAIN
    tbl[3]  = '{0, 7'h00, 0, 0,  2, 0, 7'h1B, 0, 1};  // k+33: SIDE
    tbl[4]  = '{0, 7'h00, 0, 6,  2, 0, 7'h1B, 0, 1};  // k+40: still SIDE
    tbl[5]  = '{0, 7'h00, 0, 0,  3, 0, 7'h1B, 0, 1};  // k+41: DRINK
    tbl[6]  = '{0, 7'h00, 0, 2,  3, 0, 7'h1B, 0, 1};  // k+44: still DRINK
    tbl[7]  = '{0, 7'h00, 0, 0,  4, 1, 7'h1B, 0, 1};  // k+45: READY
    tbl[8]  = '{0, 7'h00, 1, 0,  0, 0, 7'h00, 0, 0};  // pickup
    tbl[9]  = '{1, 7'h44, 0, 0,  0, 0, 7'h00, 1, 0};
    tbl[10] = '{0, 7'h00, 0, 0,  1, 0, 7'h44, 0, 1};  // MAIN, 16 cycles
    tbl[11] = '{0, 7'h00, 1, 0,  1, 0, 7'h44, 0, 1};  // pickup in MAIN ignored
    tbl[12] = '{0, 7'h00, 0, 13, 1, 0, 7'h44, 0, 1};  // 16th MAIN cycle
    tbl[13] = '{0, 7'h00, 0, 0,  4, 1, 7'h44, 0, 1};  // straight to READY
    tbl[14] = '{0, 7'h00, 1, 0,  0, 0, 7'h00, 0, 0};

    reset     = 1'b1;
    ord_valid = 1'b0;
    ord_data  = '0;
    pickup    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_stage",     stage,       0);
    check("reset_busy",      busy,        0);
    check("reset_ready",     ord_ready,   1);
    check("reset_drop",      ord_drop,    0);
    check("reset_sv",        serve_valid, 0);
    check("reset_serving",   serving,     0);
    check("reset_qc",        queue_count, 0);
    reset = 1'b0;
    @(negedge clk);
    compare_model();

    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].p);
      for (int h = 0; h < tbl[i].hold; h++) tick(0, '0, 0);
      check($sformatf("vec%0d_stage", i),   stage,       tbl[i].e_stage);
      check($sformatf("vec%0d_sv", i),      serve_valid, tbl[i].e_sv);
      check($sformatf("vec%0d_serving", i), serving,     tbl[i].e_serving);
      check($sformatf("vec%0d_qc", i),      queue_count, tbl[i].e_qc);
      check($sformatf("vec%0d_busy", i),    busy,        tbl[i].e_busy);
    end

    // ---- overflow: five pushes while the station is busy ----
    tick(1, 7'h00, 0);
    tick(0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      w[i] = 7'($urandom);
      tick(1, w[i], 0);
      if (i == 3) begin
        check("ovf_qc_full", queue_count, 4);
        check("ovf_not_ready", ord_ready, 0);
      end
    end
    check("ovf_drop_pulse", ord_drop, 1);
    check("ovf_qc_held", queue_count, 4);
    tick(0, '0, 0);
    check("ovf_drop_once", ord_drop, 0);
    got.delete();
    for (int n = 0; n < 2000 && got.size() < 5; n++) begin
      if (serve_valid) got.push_back(serving);
      tick(0, '0, serve_valid);
    end
    check("ovf_served_count", got.size(), 5);
    if (got.size() == 5) begin
      check("ovf_first", got[0], 7'h00);
      for (int i = 0; i < 4; i++) check($sformatf("ovf_order%0d", i), got[i+1], w[i]);
    end

    // ---- reset mid-SIDE with two orders queued ----
    tick(1, 7'h02, 0);
    tick(0, '0, 0);
    tick(1, 7'h7F, 0);
    tick(1, 7'h11, 0);
    for (int n = 0; n < 14; n++) tick(0, '0, 0);
    check("pre_rst_side", stage, 2);
    check("pre_rst_qc", queue_count, 2);
    reset_mid();

    // ---- push coincident with pickup in READY ----
    tick(1, 7'h00, 0);
    tick(0, '0, 0);
    tick(1, 7'h40, 0);
    wait_ready("coin_reach_ready");
    check("coin_qc_before", queue_count, 1);
    tick(1, 7'h55, 1);
    check("coin_idle", stage, 0);
    check("coin_qc_push", queue_count, 2);
    tick(0, '0, 0);
    check("coin_next_main", stage, 1);
    check("coin_next_word", serving, 7'h40);
    check("coin_qc_after", queue_count, 1);

    // ---- randomized run against the model ----
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 5) == 0), 7'($urandom), ($urandom_range(0, 3) == 0));
    end
    reset_mid();

`ifdef PICKUP_TIMEOUT_EN
    // ---- pickup timeout ----
    tick(1, 7'h00, 0);
    wait_ready("to_reach_ready");
    for (int n = 0; n < 63; n++) tick(0, '0, 0);
    check("to_still_ready", stage, 4);
    tick(0, '0, 0);
    check("to_expired_idle", stage, 0);
    check("to_serving_clr", serving, 0);
    check("to_cnt_one", timeout_cnt, 1);
    tick(1, 7'h00, 0);
    wait_ready("to2_reach_ready");
    for (int n = 0; n < 63; n++) tick(0, '0, 0);
    tick(0, '0, 1);
    check("to_pickup_wins_idle", stage, 0);
    check("to_pickup_wins_cnt", timeout_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
